job_seq: RTL
============

Name: job_seq

Overview:
- Sequences one HPU job: item-memory fill (matw phase), then compute/stream (run phase) over a configured number of blocks.
- Latches the job configuration and drives the datapath control lines: matw, run, last, mat_a, addr_i, addr_j.
- Replaces the fixed n-gram / addr_i / item-count constants and the ad-hoc matw clear in the register block.
- Sits between the AXI-Lite register file and the src/s/exe/out/dst control blocks, all on the stream clock.

Parameters:
ADDR_W, 20, width of addr_i / addr_j configuration and outputs
ITEM_W, 16, width of item-memory count and mat_a
BLK_W, 16, width of block count
WDT_CYCLES, 65535, watchdog limit in cycles (used only with SEQ_WDT_EN)

Ports:
clk  in  1  stream clock
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle job start request
abort  in  1  one-cycle abort request
skip_matw  in  1  when set at start, skip the item-memory fill
cfg_item_num  in  ITEM_W  last mat_a index to write (count-1)
cfg_ngram  in  ADDR_W  n-gram depth, forwarded to addr_j
cfg_addr_i  in  ADDR_W  words per block minus 1, forwarded to addr_i
cfg_blocks  in  BLK_W  number of blocks minus 1
s_fin  in  1  pulse: datapath finished one block
dst_last_hs  in  1  TVALID&TREADY&TLAST beat accepted on master stream
matw  out  1  item-memory write phase
mat_a  out  ITEM_W  item-memory write address
run  out  1  datapath enable (datapath rst = ~run)
last  out  1  current block is final block
addr_i  out  ADDR_W  latched cfg_addr_i
addr_j  out  ADDR_W  latched cfg_ngram
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at job end (ok, abort or timeout)
status  out  2  00 none, 01 ok, 10 aborted, 11 timeout
blk_cnt  out  BLK_W  blocks completed in current job

Behaviour:
- Reset (async, active-high): state IDLE; all outputs 0.
- States: IDLE, MATW, ARM, RUN, DRAIN, DONE. Encoding is free.
- IDLE:
  - matw=run=last=0.
  - On start: latch cfg_*; addr_i/addr_j update the next cycle; clear blk_cnt and status.
  - Next state is ARM if skip_matw, else MATW.
  - abort is ignored in IDLE.
- MATW:
  - matw=1; mat_a starts at 0 and increments by 1 every cycle.
  - When mat_a==cfg_item_num: next state ARM, matw=0 and mat_a=0 next cycle.
  - cfg_item_num=0 gives exactly one matw cycle.
- ARM: exactly one cycle with run=0, so datapath reset is guaranteed between jobs; then RUN.
- RUN:
  - run=1.
  - Each s_fin pulse increments blk_cnt (wraps at BLK_W, not reachable in practice).
  - last=1 combinationally whenever blk_cnt==cfg_blocks.
  - s_fin while blk_cnt==cfg_blocks goes to DRAIN; blk_cnt becomes cfg_blocks+1.
- DRAIN: run=1, last=1; further s_fin ignored. dst_last_hs goes to DONE.
- DONE: run=0, last=0; done=1 for this cycle; status=01; next state IDLE.
- abort in MATW/ARM/RUN/DRAIN:
  - Next cycle is IDLE with matw=run=last=0 and mat_a=0.
  - done pulses once, status=10.
- Priority in the same cycle: rst > abort > s_fin/dst_last_hs > start.
- start while busy is ignored.
- status and blk_cnt hold until the next accepted start or reset.
- addr_i/addr_j hold the last latched values after the job ends.
- Config inputs are sampled only on an accepted start; changes mid-job have no effect.

Optional Feature:
SEQ_WDT_EN:
- Defined:
  - A watchdog counter runs in RUN and DRAIN.
  - It clears on entry to RUN, on every s_fin and on every dst_last_hs.
  - When it reaches WDT_CYCLES, the job ends as for abort, but status=11.
- Undefined:
  - No counter is built; RUN/DRAIN wait indefinitely; status 11 never occurs.

Test Plan:
- Basic job: cfg_item_num=99, skip_matw=0, start → matw high exactly 100 cycles, mat_a 0..99, one run=0 ARM cycle, then run=1.
- Three-block run: cfg_blocks=2, three s_fin pulses then dst_last_hs → last rises after 2nd s_fin, blk_cnt=3, done pulse, status=01, run=0.
- skip_matw=1, cfg_blocks=0 → matw never asserts; run and last both high from RUN entry; DONE after s_fin then dst_last_hs.
- abort during MATW at mat_a=40 → next cycle IDLE, matw=0, mat_a=0, done=1, status=10. abort plus s_fin in the same RUN cycle → abort wins, blk_cnt unchanged.
- start during RUN with different cfg_addr_i → ignored; addr_i keeps its original value. rst asserted mid-RUN → all outputs 0 immediately (asynchronous).
- SEQ_WDT_EN, WDT_CYCLES=20, no s_fin after RUN entry → done at the 20th idle cycle with status=11. Without the macro, same stimulus → still RUN after 100 cycles.

Source files
------------

// File: rtl/job_seq.sv
// job_seq: sequences one HPU job (item-memory fill, then block compute/stream) and
// drives the datapath control lines. Optional watchdog is built when SEQ_WDT_EN is defined.
`default_nettype none

module job_seq #(
  parameter int ADDR_W     = 20,
  parameter int ITEM_W     = 16,
  parameter int BLK_W      = 16,
  parameter int WDT_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              skip_matw,
  input  logic [ITEM_W-1:0] cfg_item_num,
  input  logic [ADDR_W-1:0] cfg_ngram,
  input  logic [ADDR_W-1:0] cfg_addr_i,
  input  logic [BLK_W-1:0]  cfg_blocks,
  input  logic              s_fin,
  input  logic              dst_last_hs,
  output logic              matw,
  output logic [ITEM_W-1:0] mat_a,
  output logic              run,
  output logic              last,
  output logic [ADDR_W-1:0] addr_i,
  output logic [ADDR_W-1:0] addr_j,
  output logic              busy,
  output logic              done,
  output logic [1:0]        status,
  output logic [BLK_W-1:0]  blk_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MATW,
    S_ARM,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [1:0] ST_NONE    = 2'b00;
  localparam logic [1:0] ST_OK      = 2'b01;
  localparam logic [1:0] ST_ABORT   = 2'b10;
  localparam logic [1:0] ST_TIMEOUT = 2'b11;

  if (WDT_CYCLES < 2) begin : g_bad_wdt
    $error("job_seq: WDT_CYCLES must be at least 2");
  end

  state_t            state, state_nxt;
  logic [ITEM_W-1:0] item_num_q;
  logic [BLK_W-1:0]  blocks_q;
  logic              accept_start;
  logic              end_ok;
  logic              end_abort;
  logic              end_wdt;
  logic              blk_inc;
  logic              wdt_fire;
  logic              final_blk;

  assign final_blk = (blk_cnt == blocks_q);

`ifdef SEQ_WDT_EN
  localparam int              WDT_W    = $clog2(WDT_CYCLES + 1);
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

  logic [WDT_W-1:0] wdt_cnt;
  logic             wdt_active;
  logic             wdt_kick;

  assign wdt_active = (state == S_RUN) || (state == S_DRAIN);
  assign wdt_kick   = s_fin || dst_last_hs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdt_cnt <= '0;
    end else if (state == S_ARM || (wdt_active && wdt_kick)) begin
      wdt_cnt <= '0;
    end else if (wdt_active) begin
      wdt_cnt <= wdt_cnt + WDT_W'(1);
    end
  end

  // Fires on the cycle that would bring the count to WDT_CYCLES, so the job
  // ends after exactly WDT_CYCLES quiet RUN/DRAIN cycles.
  assign wdt_fire = wdt_active && !wdt_kick && (wdt_cnt == WDT_LAST);
`else
  assign wdt_fire = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_nxt    = state;
    accept_start = 1'b0;
    end_ok       = 1'b0;
    end_abort    = 1'b0;
    end_wdt      = 1'b0;
    blk_inc      = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          accept_start = 1'b1;
          state_nxt    = skip_matw ? S_ARM : S_MATW;
        end
      end
      S_MATW: begin
        if (abort) begin
          end_abort = 1'b1;
          state_nxt = S_IDLE;
        end else if (mat_a == item_num_q) begin
          state_nxt = S_ARM;
        end
      end
      S_ARM: begin
        if (abort) begin
          end_abort = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          end_abort = 1'b1;
          state_nxt = S_IDLE;
        end else if (s_fin) begin
          blk_inc = 1'b1;
          if (final_blk) state_nxt = S_DRAIN;
        end else if (wdt_fire) begin
          end_wdt   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (abort) begin
          end_abort = 1'b1;
          state_nxt = S_IDLE;
        end else if (dst_last_hs) begin
          end_ok    = 1'b1;
          state_nxt = S_DONE;
        end else if (wdt_fire) begin
          end_wdt   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Job configuration and result registers; they only change on an accepted
  // start or at job end, so they hold between jobs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      item_num_q <= '0;
      blocks_q   <= '0;
      addr_i     <= '0;
      addr_j     <= '0;
      blk_cnt    <= '0;
      status     <= ST_NONE;
      done       <= 1'b0;
    end else begin
      if (accept_start) begin
        item_num_q <= cfg_item_num;
        blocks_q   <= cfg_blocks;
        addr_i     <= cfg_addr_i;
        addr_j     <= cfg_ngram;
      end

      if (accept_start)  blk_cnt <= '0;
      else if (blk_inc)  blk_cnt <= blk_cnt + BLK_W'(1);

      if (accept_start)   status <= ST_NONE;
      else if (end_ok)    status <= ST_OK;
      else if (end_abort) status <= ST_ABORT;
      else if (end_wdt)   status <= ST_TIMEOUT;

      // Registered so the pulse lands in DONE for a normal end, and in the
      // first IDLE cycle for abort/timeout.
      done <= end_ok || end_abort || end_wdt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mat_a <= '0;
    end else if (state == S_MATW && state_nxt == S_MATW) begin
      mat_a <= mat_a + ITEM_W'(1);
    end else begin
      mat_a <= '0;
    end
  end

  assign matw = (state == S_MATW);
  assign run  = (state == S_RUN) || (state == S_DRAIN);
  assign last = (state == S_DRAIN) || ((state == S_RUN) && final_blk);
  assign busy = (state != S_IDLE);

endmodule

`default_nettype wire
